thunderbird_lamp_decoder: RTL

THUNDERBIRD_LAMP_DECODER -- requirements
Module: thunderbird_lamp_decoder

---
 rtl/thunderbird_lamp_decoder.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/thunderbird_lamp_decoder.sv
// Decodes sampled Thunderbird tail-lamp patterns into a direction, completion
// pulses and per-side/error counters; every output comes straight from a flop.
module thunderbird_lamp_decoder #(
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sample_en,
  input  logic               LA,
  input  logic               LB,
  input  logic               LC,
  input  logic               RA,
  input  logic               RB,
  input  logic               RC,
  output logic [1:0]         dir,
  output logic               left_done,
  output logic               right_done,
  output logic [COUNT_W-1:0] left_count,
  output logic [COUNT_W-1:0] right_count,
  output logic               seq_err,
  output logic [COUNT_W-1:0] err_count
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_L1   = 3'd1,
    S_L2   = 3'd2,
    S_L3   = 3'd3,
    S_R1   = 3'd4,
    S_R2   = 3'd5,
    S_R3   = 3'd6,
    S_ERR  = 3'd7
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         dir_q, dir_d;
  logic               left_done_q, left_done_d;
  logic               right_done_q, right_done_d;
  logic [COUNT_W-1:0] left_count_q, left_count_d;
  logic [COUNT_W-1:0] right_count_q, right_count_d;
  logic               seq_err_q, seq_err_d;
  logic [COUNT_W-1:0] err_count_q, err_count_d;

  logic [2:0] lamp_l_s;
  logic [2:0] lamp_r_s;
  logic       l_off_s;
  logic       r_off_s;

  assign lamp_l_s = {LC, LB, LA};
  assign lamp_r_s = {RA, RB, RC};
  assign l_off_s  = (lamp_l_s == 3'b000);
  assign r_off_s  = (lamp_r_s == 3'b000);

  // Next-state and output decode; anything not on the legal path, including a
  // lit lamp on both sides at once, falls through to ERR.
  always_comb begin
    state_d       = state_q;
    dir_d         = dir_q;
    left_done_d   = 1'b0;
    right_done_d  = 1'b0;
    left_count_d  = left_count_q;
    right_count_d = right_count_q;
    seq_err_d     = seq_err_q;
    err_count_d   = err_count_q;

    if (sample_en) begin
      case (state_q)
        S_IDLE: begin
          if (l_off_s && r_off_s)                          state_d = S_IDLE;
          else if ((lamp_l_s == 3'b001) && r_off_s)        state_d = S_L1;
          else if (l_off_s && (lamp_r_s == 3'b100))        state_d = S_R1;
          else                                             state_d = S_ERR;
        end
        S_L1: state_d = ((lamp_l_s == 3'b011) && r_off_s) ? S_L2 : S_ERR;
        S_L2: state_d = ((lamp_l_s == 3'b111) && r_off_s) ? S_L3 : S_ERR;
        S_L3: begin
          if (l_off_s && r_off_s) begin
            state_d      = S_IDLE;
            left_done_d  = 1'b1;
            left_count_d = left_count_q + COUNT_W'(1);
          end else begin
            state_d = S_ERR;
          end
        end
        S_R1: state_d = (l_off_s && (lamp_r_s == 3'b110)) ? S_R2 : S_ERR;
        S_R2: state_d = (l_off_s && (lamp_r_s == 3'b111)) ? S_R3 : S_ERR;
        S_R3: begin
          if (l_off_s && r_off_s) begin
            state_d       = S_IDLE;
            right_done_d  = 1'b1;
            right_count_d = right_count_q + COUNT_W'(1);
          end else begin
            state_d = S_ERR;
          end
        end
        S_ERR:   state_d = (l_off_s && r_off_s) ? S_IDLE : S_ERR;
        default: state_d = S_ERR;
      endcase

      if ((state_d == S_ERR) && (state_q != S_ERR) && (err_count_q != {COUNT_W{1'b1}})) begin
        err_count_d = err_count_q + COUNT_W'(1);
      end else begin
        err_count_d = err_count_q;
      end

      case (state_d)
        S_IDLE:                 dir_d = 2'b00;
        S_L1, S_L2, S_L3:       dir_d = 2'b01;
        S_R1, S_R2, S_R3:       dir_d = 2'b10;
        default:                dir_d = 2'b11;
      endcase
      seq_err_d = (state_d == S_ERR);
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      dir_q         <= 2'b00;
      left_done_q   <= 1'b0;
      right_done_q  <= 1'b0;
      left_count_q  <= '0;
      right_count_q <= '0;
      seq_err_q     <= 1'b0;
      err_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      dir_q         <= dir_d;
      left_done_q   <= left_done_d;
      right_done_q  <= right_done_d;
      left_count_q  <= left_count_d;
      right_count_q <= right_count_d;
      seq_err_q     <= seq_err_d;
      err_count_q   <= err_count_d;
    end
  end

  assign dir         = dir_q;
  assign left_done   = left_done_q;
  assign right_done  = right_done_q;
  assign left_count  = left_count_q;
  assign right_count = right_count_q;
  assign seq_err     = seq_err_q;
  assign err_count   = err_count_q;

endmodule
